// File: rtl/dog_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dog_pkg : shared widths, saturation bounds and FSM encoding       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package dog_pkg;
    localparam int DOG_W   = 8;
    localparam int DOG_MAX = 127;
    localparam int DOG_MIN = -128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } dog_state_e;
endpackage
`default_nettype wire

// File: rtl/dog_sat_sub.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dog_sat_sub : one subtract -> shift -> saturate lane, 2 stages    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dog_sat_sub
    import dog_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1_en,
    input  logic             s2_en,
    input  logic [DOG_W-1:0] a,
    input  logic [DOG_W-1:0] b,
    output logic [DOG_W-1:0] diff
);
    localparam logic [DOG_W-1:0] SAT_HI = DOG_W'(DOG_MAX);
    localparam logic [DOG_W-1:0] SAT_LO = DOG_W'(DOG_MIN);

    logic signed [DOG_W:0]   d9_q, d9_d;
    logic signed [DOG_W:0]   w_shr;
    logic        [DOG_W-1:0] diff_q, diff_d;

    always_comb begin
        d9_d   = d9_q;
        diff_d = diff_q;
        w_shr  = d9_q >>> SHIFT;
        if (s1_en) begin
            d9_d = {1'b0, b} - {1'b0, a};
        end
        // Both stages hold during gaps so the output keeps its last value.
        if (s2_en) begin
            if (w_shr > DOG_MAX) begin
                diff_d = SAT_HI;
            end else if (w_shr < DOG_MIN) begin
                diff_d = SAT_LO;
            end else begin
                diff_d = w_shr[DOG_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d9_q   <= '0;
            diff_q <= '0;
        end else begin
            d9_q   <= d9_d;
            diff_q <= diff_d;
        end
    end

    assign diff = diff_q;
endmodule
`default_nettype wire

// File: rtl/dog_diff_source.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dog_diff_source : DoG layer producer with frame/position tracking |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dog_diff_source
    import dog_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48,
    parameter int SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     pix_valid,
    input  logic [7:0]               g0,
    input  logic [7:0]               g1,
    input  logic [7:0]               g2,
    input  logic [7:0]               g3,
    output logic [7:0]               diff0,
    output logic [7:0]               diff1,
    output logic [7:0]               diff2,
    output logic                     complete1,
    output logic [$clog2(IMG_W)-1:0] col_out,
    output logic [$clog2(IMG_H)-1:0] row_out,
    output logic                     frame_done,
    output logic                     ovf_err
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    dog_state_e     state_q, state_d;
    logic [CW-1:0]  col_q, col_d, col1_q, col1_d, col2_q, col2_d;
    logic [RW-1:0]  row_q, row_d, row1_q, row1_d, row2_q, row2_d;
    logic           v1_q, v1_d, v2_q, v2_d;
    logic           last1_q, last1_d, last2_q, last2_d;
    logic           done_q, done_d, ovf_q, ovf_d;
    logic           w_accept, w_last_pix;

    logic [3:0][7:0] w_g;
    logic [2:0][7:0] w_diff;

    assign w_g        = {g3, g2, g1, g0};
    assign w_accept   = (state_q == ST_ACTIVE) && pix_valid;
    assign w_last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        v1_d    = w_accept;
        last1_d = w_accept && w_last_pix;
        col1_d  = w_accept ? col_q : col1_q;
        row1_d  = w_accept ? row_q : row1_q;
        v2_d    = v1_q;
        last2_d = last1_q;
        col2_d  = v1_q ? col1_q : col2_q;
        row2_d  = v1_q ? row1_q : row2_q;
        done_d  = last2_q;
        ovf_d   = ovf_q | (pix_valid && (state_q != ST_ACTIVE));

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_ACTIVE;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_ACTIVE: begin
                if (pix_valid) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (w_last_pix) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            // Leave DRAIN only once the done pulse is on the output.
            ST_DRAIN: begin
                if (done_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            col1_q  <= '0;
            row1_q  <= '0;
            col2_q  <= '0;
            row2_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            col1_q  <= col1_d;
            row1_q  <= row1_d;
            col2_q  <= col2_d;
            row2_q  <= row2_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            last1_q <= last1_d;
            last2_q <= last2_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_lane
        dog_sat_sub #(
            .SHIFT (SHIFT)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .s1_en (w_accept),
            .s2_en (v1_q),
            .a     (w_g[i]),
            .b     (w_g[i+1]),
            .diff  (w_diff[i])
        );
    end

    assign diff0      = w_diff[0];
    assign diff1      = w_diff[1];
    assign diff2      = w_diff[2];
    assign complete1  = v2_q;
    assign col_out    = col2_q;
    assign row_out    = row2_q;
    assign frame_done = done_q;
    assign ovf_err    = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_dog_diff_source.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dog_diff_source : scoreboard bench, SHIFT=0 and SHIFT=1 DUTs   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_dog_diff_source;
    localparam int W = 4;
    localparam int H = 2;

    typedef struct {
        logic [7:0] g0, g1, g2, g3;
        logic [7:0] e0, e1, e2;
        logic [7:0] f0, f1, f2;
    } vec_t;

    typedef struct {
        logic [7:0] e0, e1, e2;
        logic [7:0] f0, f1, f2;
        logic [1:0] col;
        logic       row;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] g0 = '0, g1 = '0, g2 = '0, g3 = '0;
    logic [7:0] diff0, diff1, diff2, s_diff0, s_diff1, s_diff2;
    logic       complete1, s_complete1, frame_done, s_frame_done, ovf_err, s_ovf_err;
    logic [1:0] col_out, s_col_out;
    logic       row_out, s_row_out;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   m_col = 0;
    int   m_row = 0;
    vec_t vt[4];
    exp_t sb[$];
    exp_t cur;
    logic exp_done = 1'b0;
    logic [7:0] l0 = '0, l1 = '0, l2 = '0, k0 = '0, k1 = '0, k2 = '0;

    dog_diff_source #(.IMG_W(W), .IMG_H(H), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .g0(g0), .g1(g1), .g2(g2), .g3(g3),
        .diff0(diff0), .diff1(diff1), .diff2(diff2), .complete1(complete1),
        .col_out(col_out), .row_out(row_out), .frame_done(frame_done), .ovf_err(ovf_err)
    );

    dog_diff_source #(.IMG_W(W), .IMG_H(H), .SHIFT(1)) dut_s1 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .g0(g0), .g1(g1), .g2(g2), .g3(g3),
        .diff0(s_diff0), .diff1(s_diff1), .diff2(s_diff2), .complete1(s_complete1),
        .col_out(s_col_out), .row_out(s_row_out), .frame_done(s_frame_done), .ovf_err(s_ovf_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever complete1 is presented.
    always @(negedge clk) begin
        if (!rst) begin
            {l0, l1, l2, k0, k1, k2} = '0;
            exp_done = 1'b0;
        end else begin
            chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
            if (frame_done) n_done++;
            exp_done = 1'b0;
            chk("s1_complete1", {31'd0, s_complete1}, {31'd0, complete1});
            if (complete1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_complete1", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    chk("latency", cyc, cur.cyc);
                    chk("diff0", {24'd0, diff0}, {24'd0, cur.e0});
                    chk("diff1", {24'd0, diff1}, {24'd0, cur.e1});
                    chk("diff2", {24'd0, diff2}, {24'd0, cur.e2});
                    chk("s1_diff0", {24'd0, s_diff0}, {24'd0, cur.f0});
                    chk("s1_diff1", {24'd0, s_diff1}, {24'd0, cur.f1});
                    chk("s1_diff2", {24'd0, s_diff2}, {24'd0, cur.f2});
                    chk("col_out", {30'd0, col_out}, {30'd0, cur.col});
                    chk("row_out", {31'd0, row_out}, {31'd0, cur.row});
                    {l0, l1, l2} = {cur.e0, cur.e1, cur.e2};
                    {k0, k1, k2} = {cur.f0, cur.f1, cur.f2};
                    if (cur.col == 2'(W - 1) && cur.row == 1'(H - 1)) exp_done = 1'b1;
                end
            end else begin
                chk("hold", {8'd0, diff0, diff1, diff2}, {8'd0, l0, l1, l2});
                chk("s1_hold", {8'd0, s_diff0, s_diff1, s_diff2}, {8'd0, k0, k1, k2});
            end
        end
    end

    task automatic start_frame();
        frame_start = 1'b1;
        m_col = 0;
        m_row = 0;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic drive_pix(input int vi);
        exp_t e;
        {g0, g1, g2, g3} = {vt[vi].g0, vt[vi].g1, vt[vi].g2, vt[vi].g3};
        pix_valid = 1'b1;
        e.e0 = vt[vi].e0; e.e1 = vt[vi].e1; e.e2 = vt[vi].e2;
        e.f0 = vt[vi].f0; e.f1 = vt[vi].f1; e.f2 = vt[vi].f2;
        e.col = 2'(m_col);
        e.row = 1'(m_row);
        e.cyc = cyc + 2;
        sb.push_back(e);
        if (m_col == W - 1) begin
            m_col = 0;
            m_row = m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Returns one cycle after frame_done, ready for a back-to-back start.
    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("frame_done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(nm, {diff0, diff1, diff2, complete1, col_out, row_out, frame_done, ovf_err},
                {8'd0, 8'd0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        //             g0     g1     g2     g3     e0     e1     e2     f0     f1     f2
        vt[0] = '{8'd10, 8'd20, 8'd40, 8'd35, 8'd10, 8'd20, 8'hFB, 8'd5,  8'd10, 8'hFD};
        vt[1] = '{8'd0,  8'd255,8'd0,  8'd200,8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h80, 8'd100};
        vt[2] = '{8'd200,8'd100,8'd100,8'd255,8'h9C, 8'd0,  8'h7F, 8'hCE, 8'd0,  8'd77};
        vt[3] = '{8'd50, 8'd60, 8'd30, 8'd30, 8'd10, 8'hE2, 8'd0,  8'd5,  8'hF1, 8'd0};

        #1 rst = 1'b0;
        #1 check_reset_outputs("reset_state");
        idle_cycles(2);
        rst = 1'b1;
        idle_cycles(2);

        // Frame A: contiguous basic subtraction
        start_frame();
        for (int i = 0; i < 8; i++) drive_pix(0);
        wait_done();

        // Frame B, back-to-back: gapped input, saturation, ignored frame_start
        start_frame();
        drive_pix(1); idle_cycles(1);
        drive_pix(2); idle_cycles(1);
        frame_start = 1'b1; idle_cycles(1); frame_start = 1'b0;
        drive_pix(3); idle_cycles(1);
        drive_pix(0); idle_cycles(1);
        drive_pix(1); drive_pix(2); drive_pix(3); drive_pix(1);
        wait_done();

        // Frame C, back-to-back again
        start_frame();
        for (int i = 0; i < 8; i++) drive_pix(i % 4);
        wait_done();
        chk("ovf_after_b2b", {31'd0, ovf_err}, 32'd0);

        // Pixel while idle: dropped, sticky error
        idle_cycles(2);
        g0 = 8'd1; pix_valid = 1'b1;
        idle_cycles(1);
        pix_valid = 1'b0;
        idle_cycles(3);
        chk("ovf_idle", {31'd0, ovf_err}, 32'd1);
        chk("s1_ovf_idle", {31'd0, s_ovf_err}, 32'd1);

        // Reset mid-frame after five pixels
        start_frame();
        for (int i = 0; i < 5; i++) drive_pix(i % 4);
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_midframe");
        sb.delete();
        idle_cycles(2);
        rst = 1'b1;
        idle_cycles(6);
        chk("no_done_after_reset", n_done, 3);

        // Fresh frame after reset starts at (0,0)
        start_frame();
        for (int i = 0; i < 8; i++) drive_pix(3 - (i % 4));
        wait_done();
        idle_cycles(3);

        chk("done_count", n_done, 4);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dog_diff_source.md
Name: dog_diff_source

Overview:
Producer side of the DoG-extremum interface. Accepts four co-registered Gaussian-blurred pixel streams (scales 0..3) and forms three signed 8-bit difference-of-Gaussian layers: diff0=g1-g0, diff1=g2-g1, diff2=g3-g2. It presents them with the complete1 qualifier in the form local_extreme consumes. It also frames the stream: it counts rows and columns, reports the position of each output pixel, and flags the end of frame. It sits between the Gaussian pyramid stage and local_extreme.

Parameters:
IMG_W, 64, pixels per row (>=2)
IMG_H, 48, rows per frame (>=2)
SHIFT, 0, arithmetic right shift applied to each 9-bit difference before saturation (0..3)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
frame_start  input  1  one-cycle pulse, arms a new frame
pix_valid  input  1  g0..g3 valid this cycle
g0  input  8  unsigned Gaussian pixel, scale 0
g1  input  8  unsigned Gaussian pixel, scale 1
g2  input  8  unsigned Gaussian pixel, scale 2
g3  input  8  unsigned Gaussian pixel, scale 3
diff0  output  8  signed DoG layer 0
diff1  output  8  signed DoG layer 1
diff2  output  8  signed DoG layer 2
complete1  output  1  diff0..2 valid this cycle
col_out  output  clog2(IMG_W)  column of current output pixel
row_out  output  clog2(IMG_H)  row of current output pixel
frame_done  output  1  one-cycle pulse after the last pixel of a frame is output
ovf_err  output  1  sticky flag: pixel received while not ACTIVE

Behaviour:
- Reset state: while rst=0, all outputs are 0 and the FSM is in IDLE. Reset takes effect immediately, including mid-frame; the partial frame is discarded and no frame_done is produced for it.
- FSM states:
  - IDLE: on frame_start, go to ACTIVE and clear col/row counters.
  - ACTIVE: count each accepted pixel (pix_valid=1). col wraps IMG_W-1 -> 0, then row increments. Accepting pixel (IMG_W-1, IMG_H-1) moves the FSM to DRAIN.
  - DRAIN: wait until the last pixel leaves the pipeline, pulse frame_done for one cycle, return to IDLE.
- frame_start during ACTIVE or DRAIN is ignored. frame_start in the same cycle as a pixel while in IDLE: the FSM arms, and that pixel is not accepted.
- pix_valid in IDLE or DRAIN: the pixel is dropped and ovf_err is set. ovf_err clears only on reset.
- Pipeline, fixed 2-cycle latency from an accepted pixel to complete1=1:
  - Stage 1 registers the 9-bit signed differences {1'b0,g(k+1)} - {1'b0,g(k)}, range -255..255.
  - Stage 2 applies an arithmetic right shift by SHIFT, then saturates to -128..127.
  - col/row are pipelined alongside the data and match diffN exactly.
- Gaps in pix_valid produce matching gaps in complete1; there are no bubbles and no reordering.
- When complete1=0, diff0..2 hold their last values.
- frame_done asserts in the cycle after complete1 for the last pixel, i.e. 3 cycles after that pixel was accepted. The next frame_start is accepted in the cycle after the frame_done pulse.

Decomposition:
- Shared package dog_pkg: DOG_W=8, DOG_MAX=127, DOG_MIN=-128, and the FSM state encoding (IDLE, ACTIVE, DRAIN).
- Sub-module dog_sat_sub: one 2-stage subtract/shift/saturate lane, instantiated three times.
- FSM, counters and position pipeline live in the top module.

Test Plan:
- Basic subtraction. Bench uses IMG_W=4, IMG_H=2. Reset, frame_start, then 8 pixels with g0=10, g1=20, g2=40, g3=35 -> complete1 is high exactly 8 cycles starting 2 cycles after the first pixel; diff0=10, diff1=20, diff2=-5; col/row run (0,0)..(3,1); frame_done pulses once, 1 cycle after the last complete1.
- Saturation. g0=0, g1=255, g2=0, g3=200 with SHIFT=0 -> diff0=127, diff1=-128, diff2=127. The same inputs with SHIFT=1 -> diff0=127, diff1=-128, diff2=100.
- Gapped input. pix_valid toggles 1,0,1,0 -> complete1 reproduces the same pattern delayed by 2 cycles; diffs hold during the gaps; col advances only on valid pixels.
- Error and ignore handling. pix_valid=1 while IDLE -> ovf_err=1 and no complete1. A second frame_start mid-frame is ignored, so counters do not reset.
- Reset mid-frame. Drive rst=0 after pixel 5 -> all outputs go to 0 asynchronously; no frame_done. A fresh frame after release starts at (0,0).
- Back-to-back frames. frame_start in the cycle after frame_done -> the second frame is fully counted; two frame_done pulses in total; ovf_err stays 0.
